// File: rtl/xrv_i_align_pkg.sv
// rtl/xrv_i_align_pkg.sv - shared constants and helpers for the instruction realigner
package xrv_i_align_pkg;

  // Depth of the halfword queue and width of its pointers
  localparam int unsigned XRV_ALIGN_DEPTH = 4;
  localparam int unsigned HWQ_PTR_W       = 2;

  // A halfword starts a compressed instruction unless its low two bits are 2'b11
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/xrv_i_hwq.sv
// rtl/xrv_i_hwq.sv - depth-4 circular halfword queue with 1/2-entry push and pop
module xrv_i_hwq
  import xrv_i_align_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [1:0]  push_cnt,
  input  logic [15:0] push_hw0,
  input  logic [15:0] push_hw1,
  input  logic [1:0]  pop_cnt,
  output logic [15:0] h0,
  output logic [15:0] h1,
  output logic [2:0]  count
);

  logic [15:0]          mem_q [XRV_ALIGN_DEPTH];
  logic [15:0]          mem_d [XRV_ALIGN_DEPTH];
  logic [HWQ_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [HWQ_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [HWQ_PTR_W-1:0] rd_ptr_nx;
  logic [HWQ_PTR_W-1:0] wr_ptr_nx;
  logic [2:0]           count_q, count_d;

  assign rd_ptr_nx = rd_ptr_q + 2'd1;
  assign wr_ptr_nx = wr_ptr_q + 2'd1;
  assign h0        = mem_q[rd_ptr_q];
  assign h1        = mem_q[rd_ptr_nx];
  assign count     = count_q;

  // Next-state for storage, pointers and occupancy; clear drops any same-cycle push/pop
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q + pop_cnt;
    wr_ptr_d = wr_ptr_q + push_cnt;
    count_d  = count_q + {1'b0, push_cnt} - {1'b0, pop_cnt};
    if (push_cnt != 2'd0) begin
      mem_d[wr_ptr_q] = push_hw0;
    end
    if (push_cnt == 2'd2) begin
      mem_d[wr_ptr_nx] = push_hw1;
    end
    if (clr) begin
      mem_d    = mem_q;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = 3'd0;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; count gates every read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/xrv_i_align.sv
// rtl/xrv_i_align.sv - realigns fetch words into 16/32-bit instructions with PC tracking
module xrv_i_align
  import xrv_i_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_is_c
);

  logic [15:0] h0, h1;
  logic [2:0]  count;
  logic        head_c, head_rdy;
  logic        push, pop;
  logic [1:0]  push_cnt, pop_cnt;
  logic [15:0] push_hw0;
  logic [30:0] head_pc_q, head_pc_d;
  logic        skip_q, skip_d;
  logic        unused_flush_pc0;

  assign unused_flush_pc0 = flush_pc[0];

  assign head_c      = is_rvc(h0);
  assign head_rdy    = head_c ? (count >= 3'd1) : (count >= 3'd2);
  assign fetch_ready = (count <= 3'd2) && !flush;
  assign instr_valid = head_rdy && !flush;
  assign instr_is_c  = instr_valid && head_c;
  assign instr_data  = !instr_valid ? 32'h0 : (head_c ? {16'h0, h0} : {h1, h0});
  assign instr_pc    = {head_pc_q, 1'b0};

  assign push     = fetch_valid && fetch_ready;
  assign pop      = instr_valid && instr_ready;
  assign push_cnt = !push ? 2'd0 : (skip_q ? 2'd1 : 2'd2);
  assign push_hw0 = skip_q ? fetch_data[31:16] : fetch_data[15:0];
  assign pop_cnt  = !pop ? 2'd0 : (head_c ? 2'd1 : 2'd2);

  xrv_i_hwq u_hwq (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push_cnt (push_cnt),
    .push_hw0 (push_hw0),
    .push_hw1 (fetch_data[31:16]),
    .pop_cnt  (pop_cnt),
    .h0       (h0),
    .h1       (h1),
    .count    (count)
  );

  // Head PC advances by the popped halfwords; a redirect reloads PC and the skip flag
  always_comb begin
    head_pc_d = head_pc_q + {29'd0, pop_cnt};
    skip_d    = skip_q && !push;
    if (flush) begin
      head_pc_d = flush_pc[31:1];
      skip_d    = flush_pc[1];
    end
  end

  // PC and skip registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_pc_q <= RESET_PC[31:1];
      skip_q    <= RESET_PC[1];
    end else begin
      head_pc_q <= head_pc_d;
      skip_q    <= skip_d;
    end
  end

endmodule
